// File: rtl/sys_defs_pkg.sv
// Shared memory-bus types and load-controller defaults.
package sys_defs;

   typedef logic [31:0] ADDR;
   typedef logic [63:0] MEM_BLOCK;

   localparam int NUM_MEM_TAGS = 15;
   typedef logic [$clog2(NUM_MEM_TAGS+1)-1:0] MEM_TAG;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } MEM_COMMAND;

   localparam int MC_DEPTH_DEF = 8;
   localparam int MC_LEN_W_DEF = 16;

   typedef enum logic [1:0] {
      MC_IDLE,
      MC_ISSUE,
      MC_DRAIN
   } MC_STATE;

endpackage

// File: rtl/aura_mc_rob.sv
// Reorder buffer: slots allocated in issue order at tail, filled out of order,
// drained in order from head.
module aura_mc_rob
   import sys_defs::*;
#(
   parameter int DEPTH = MC_DEPTH_DEF,
   parameter int SW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          alloc,
   input  logic          fill_en,
   input  logic [SW-1:0] fill_slot,
   input  MEM_BLOCK      fill_data,
   input  logic          pop,
   output logic [SW-1:0] tail,
   output logic          full,
   output logic          head_filled,
   output MEM_BLOCK      head_data
);

   logic [SW-1:0]    head;
   logic [SW:0]      count;
   logic [DEPTH-1:0] filled;
   MEM_BLOCK         slot_data [DEPTH];

   function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] p);
      return (p == SW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign full        = (count == (SW+1)'(DEPTH));
   assign head_filled = filled[head];
   assign head_data   = slot_data[head];

   always_ff @(posedge clock) begin
      if (!reset) begin
         head   <= '0;
         tail   <= '0;
         count  <= '0;
         filled <= '0;
      end else begin
         if (alloc) tail <= wrap_inc(tail);
         if (pop) begin
            head         <= wrap_inc(head);
            filled[head] <= 1'b0;
         end
         // A popped slot is always filled, so it never collides with fill_slot.
         if (fill_en) filled[fill_slot] <= 1'b1;
         case ({alloc, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (fill_en) slot_data[fill_slot] <= fill_data;
   end

endmodule

// File: rtl/aura_mem_ctrl.sv
// Load/store memory controller: issues tagged bursts of 8-byte loads, reorders
// responses through aura_mc_rob, and interleaves single-beat stores.
module aura_mem_ctrl
   import sys_defs::*;
#(
   parameter int MC_DEPTH = MC_DEPTH_DEF,
   parameter int LEN_W    = MC_LEN_W_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ld_req_valid,
   output logic             ld_req_ready,
   input  ADDR              ld_req_addr,
   input  logic [LEN_W-1:0] ld_req_len,
   output logic             ld_data_valid,
   input  logic             ld_data_ready,
   output MEM_BLOCK         ld_data,
   output logic             ld_data_last,
   input  logic             st_valid,
   output logic             st_ready,
   input  ADDR              st_addr,
   input  MEM_BLOCK         st_data,
   output MEM_COMMAND       proc2mem_command,
   output ADDR              proc2mem_addr,
   output MEM_BLOCK         proc2mem_data,
   input  MEM_TAG           mem2proc_transaction_tag,
   input  MEM_BLOCK         mem2proc_data,
   input  MEM_TAG           mem2proc_data_tag,
   output logic             busy
);

   localparam int SW = (MC_DEPTH > 1) ? $clog2(MC_DEPTH) : 1;

   MC_STATE               state;
   ADDR                   cur_addr;
   logic [LEN_W-1:0]      remaining, job_len, beat_idx;
   logic                  rr_store;
   logic [NUM_MEM_TAGS:0] tag_vld;
   logic [SW-1:0]         tag_slot [NUM_MEM_TAGS+1];

   logic          rob_full, head_filled;
   logic [SW-1:0] rob_tail;
   MEM_BLOCK      head_data;
   logic          load_elig, store_elig, grant_load, grant_store;
   logic          cmd_acc, load_acc, store_acc, rsp_hit, ld_fire;

   assign load_elig   = reset && (state == MC_ISSUE) && !rob_full;
   assign store_elig  = reset && st_valid;
   assign grant_store = store_elig && (rr_store || !load_elig);
   assign grant_load  = load_elig && !grant_store;
   assign cmd_acc     = (mem2proc_transaction_tag != '0);
   assign load_acc    = grant_load && cmd_acc;
   assign store_acc   = grant_store && cmd_acc;
   assign st_ready    = store_acc;

   assign rsp_hit       = reset && (mem2proc_data_tag != '0) && tag_vld[mem2proc_data_tag];
   assign ld_data_valid = reset && head_filled;
   assign ld_data       = head_data;
   assign ld_data_last  = ld_data_valid && (beat_idx == job_len - 1'b1);
   assign ld_fire       = ld_data_valid && ld_data_ready;
   assign ld_req_ready  = reset && (state == MC_IDLE);
   assign busy          = reset && ((state != MC_IDLE) || (|tag_vld));

   always_comb begin
      proc2mem_command = BUS_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      if (grant_store) begin
         proc2mem_command = BUS_STORE;
         proc2mem_addr    = st_addr;
         proc2mem_data    = st_data;
      end else if (grant_load) begin
         proc2mem_command = BUS_LOAD;
         proc2mem_addr    = cur_addr;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= MC_IDLE;
         cur_addr  <= '0;
         remaining <= '0;
         job_len   <= '0;
         beat_idx  <= '0;
         rr_store  <= 1'b1;
         tag_vld   <= '0;
      end else begin
         case (state)
            MC_IDLE: if (ld_req_valid) begin
               cur_addr  <= ld_req_addr & ~ADDR'(7);
               job_len   <= ld_req_len;
               remaining <= ld_req_len;
               beat_idx  <= '0;
               if (ld_req_len != '0) state <= MC_ISSUE;
            end
            MC_ISSUE: if (load_acc) begin
               cur_addr  <= cur_addr + 32'd8;
               remaining <= remaining - 1'b1;
               if (remaining == LEN_W'(1)) state <= MC_DRAIN;
            end
            MC_DRAIN: if (ld_fire && ld_data_last) state <= MC_IDLE;
            default: state <= MC_IDLE;
         endcase

         if (ld_fire) beat_idx <= beat_idx + 1'b1;

         if (store_acc)     rr_store <= 1'b0;
         else if (load_acc) rr_store <= 1'b1;

         // Free before claim so a tag reused in the same cycle stays live.
         if (rsp_hit) tag_vld[mem2proc_data_tag] <= 1'b0;
         if (load_acc) begin
            tag_vld[mem2proc_transaction_tag]  <= 1'b1;
            tag_slot[mem2proc_transaction_tag] <= rob_tail;
         end
      end
   end

   aura_mc_rob #(
      .DEPTH (MC_DEPTH),
      .SW    (SW)
   ) u_rob (
      .clock       (clock),
      .reset       (reset),
      .alloc       (load_acc),
      .fill_en     (rsp_hit),
      .fill_slot   (tag_slot[mem2proc_data_tag]),
      .fill_data   (mem2proc_data),
      .pop         (ld_fire),
      .tail        (rob_tail),
      .full        (rob_full),
      .head_filled (head_filled),
      .head_data   (head_data)
   );

endmodule

// File: doc/aura_mem_ctrl.md
AURA_MEM_CTRL -- requirements
Module: aura_mem_ctrl

Interface
REQ-001 Parameter: MC_DEPTH, default 8, number of reorder slots (maximum outstanding loads).
REQ-002 Parameter: LEN_W, default 16, width of the load beat-count field.
REQ-003 Port: clock  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  in  1  synchronous, active-low reset (0 = reset).
REQ-005 Ports: ld_req_valid in 1, ld_req_ready out 1, ld_req_addr in ADDR, ld_req_len in LEN_W  load-job handshake (base byte address, count of 8-byte beats).
REQ-006 Ports: ld_data_valid out 1, ld_data_ready in 1, ld_data out MEM_BLOCK, ld_data_last out 1  in-order load data stream.
REQ-007 Ports: st_valid in 1, st_ready out 1, st_addr in ADDR, st_data in MEM_BLOCK  single-beat store handshake for O rows.
REQ-008 Ports: proc2mem_command out MEM_COMMAND, proc2mem_addr out ADDR, proc2mem_data out MEM_BLOCK  memory request bus.
REQ-009 Ports: mem2proc_transaction_tag in MEM_TAG, mem2proc_data in MEM_BLOCK, mem2proc_data_tag in MEM_TAG  memory response bus.
REQ-010 Port: busy  out  1  high when a load job is active or any tag is outstanding.

Function
REQ-011 FSM states IDLE, ISSUE, DRAIN; ld_req_ready = 1 only in IDLE with reset deasserted.
REQ-012 IDLE: load-job handshake latches addr (bits [2:0] forced to 0) and len; next state ISSUE if len>0, else stays IDLE with no beats and no commands.
REQ-013 ISSUE: when a reorder slot is free, drive BUS_LOAD at the current address; the first BUS_LOAD appears the cycle after the job handshake.
REQ-014 Command accepted iff mem2proc_transaction_tag != 0 in the same cycle; on accept, record tag->slot, advance address by 8 (modulo 2^32), decrement remaining.
REQ-015 Tag 0 (rejected): same command and address retried next eligible cycle; no state change.
REQ-016 ISSUE -> DRAIN when remaining reaches 0; DRAIN -> IDLE in the cycle after the final beat handshakes.
REQ-017 At most one command per cycle; when load and store are both eligible, grant alternates (round-robin, store first after reset).
REQ-018 Store: drive BUS_STORE with st_addr/st_data; st_ready = 1 in exactly the cycle the store is granted and tag != 0; a rejected store remains pending.
REQ-019 Response: mem2proc_data_tag != 0 and matching a live table entry writes mem2proc_data into that slot, marks it filled, frees the tag entry; non-matching tags (including stores) are ignored.
REQ-020 ld_data_valid = head slot filled (registered; data arriving in cycle M is visible in M+1); handshake advances head and frees the slot.
REQ-021 ld_data_last = 1 on beat index len-1 only.
REQ-022 Data delivered strictly in request-address order regardless of response order.
REQ-023 Response and slot free in the same cycle: both take effect; a slot freed in cycle N is issuable in N+1.
REQ-024 All slots full: no BUS_LOAD issued; stores still eligible.
REQ-025 When no command is granted, proc2mem_command = BUS_NONE, proc2mem_addr = 0, proc2mem_data = 0.

Reset
REQ-026 While reset = 0: state IDLE, tag table and all slots invalid, head/tail = 0, remaining = 0, round-robin = store.
REQ-027 Output values under reset: proc2mem_command BUS_NONE, proc2mem_addr 0, proc2mem_data 0, ld_req_ready 0, ld_data_valid 0, ld_data_last 0, st_ready 0, busy 0.
REQ-028 Reset mid-job abandons all outstanding tags; responses after reset match no entry and are dropped.

Structure
REQ-029 MC_DEPTH default, LEN_W, and the FSM state enum live in the shared sys_defs package next to MEM_COMMAND, ADDR, MEM_BLOCK, MEM_TAG, NUM_MEM_TAGS.
REQ-030 Reorder buffer (slot array, filled bits, head/tail pointers) is sub-module aura_mc_rob; tag table and FSM stay in aura_mem_ctrl.

Verification
REQ-031 Job addr 0x1000, len 4, memory always accepts -> BUS_LOAD at 0x1000,0x1008,0x1010,0x1018 on consecutive cycles; 4 beats in order; last on beat 3.
REQ-032 Memory returns tag 0 twice on the addr 0x2000 load -> BUS_LOAD 0x2000 three times; then normal; no beat skipped or duplicated.
REQ-033 Responses returned out of order (tags for beats 2,0,1) -> ld_data still in order 0,1,2.
REQ-034 ld_data_ready held 0, len 12 -> exactly 8 loads issued, then stall; releasing ready resumes issue; 12 beats total.
REQ-035 st_valid held during a len-4 job -> commands alternate store/load; st_ready pulses once per accepted store.
REQ-036 reset = 0 with 3 tags outstanding, then late responses on those tags -> ld_data_valid stays 0, ld_req_ready = 1 after release.
